// File: rtl/mod_updown_counter_if.sv
// Bundle of control inputs and status outputs for mod_updown_counter.
// The master side drives en/up/load/load_val and observes q/tc/ovf.
interface mod_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             ovf;

   modport master (
      output en, up, load, load_val,
      input  q, tc, ovf
   );

   modport slave (
      input  en, up, load, load_val,
      output q, tc, ovf
   );
endinterface

// File: rtl/mod_updown_counter.sv
// Synchronous modulo-MODULUS up/down counter with enable, clamped parallel
// load, sticky overflow flag and combinational terminal count.
// Build option: define COUNTER_SATURATE_EN to hold at the limits instead of
// wrapping (ovf still sets on the blocked step; tc is unchanged).
module mod_updown_counter #(
   parameter int WIDTH     = 4,
   parameter int MODULUS   = 16,
   parameter int RESET_VAL = 0
) (
   input logic                 clk,
   input logic                 reset,
   mod_updown_counter_if.slave bus
);

   // Load comparison is done one bit wider so MODULUS == 2**WIDTH is representable.
   localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic             ovf_r;
   logic             ovf_nxt;
   logic             at_top;
   logic             at_bot;
   logic [WIDTH-1:0] load_q;

   assign at_top = (q_r == MAX_Q);
   assign at_bot = (q_r == '0);

   // Out-of-range load values clamp to the top of the count range.
   always_comb begin
      load_q = MAX_Q;
      if ({1'b0, bus.load_val} < MOD_W) begin
         load_q = bus.load_val;
      end
   end

   // Next count/overflow state with priority load > en; reset is applied in the register.
   always_comb begin
      q_nxt   = q_r;
      ovf_nxt = ovf_r;
      if (bus.load) begin
         q_nxt   = load_q;
         ovf_nxt = 1'b0;
      end else if (bus.en) begin
         if (bus.up) begin
            if (at_top) begin
`ifdef COUNTER_SATURATE_EN
               q_nxt = q_r;
`else
               q_nxt = '0;
`endif
               ovf_nxt = 1'b1;
            end else begin
               q_nxt = q_r + WIDTH'(1);
            end
         end else begin
            if (at_bot) begin
`ifdef COUNTER_SATURATE_EN
               q_nxt = q_r;
`else
               q_nxt = MAX_Q;
`endif
               ovf_nxt = 1'b1;
            end else begin
               q_nxt = q_r - WIDTH'(1);
            end
         end
      end
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_r   <= RST_Q;
         ovf_r <= 1'b0;
      end else begin
         q_r   <= q_nxt;
         ovf_r <= ovf_nxt;
      end
   end

   assign bus.q   = q_r;
   assign bus.ovf = ovf_r;
   assign bus.tc  = bus.en & ~bus.load & ((bus.up & at_top) | (~bus.up & at_bot));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter, WIDTH=4, MODULUS=10.
// Two instances: RESET_VAL=0 (u0) and RESET_VAL=3 (u1), driven identically.
module tb_mod_updown_counter;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mod_updown_counter_if #(.WIDTH(4)) b0 ();
   mod_updown_counter_if #(.WIDTH(4)) b1 ();

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u0 (
      .clk   (clk),
      .reset (reset),
      .bus   (b0.slave)
   );

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) u1 (
      .clk   (clk),
      .reset (reset),
      .bus   (b1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic rst, input logic e, input logic u,
                        input logic ld, input logic [3:0] lv);
      reset       = rst;
      b0.en       = e;
      b0.up       = u;
      b0.load     = ld;
      b0.load_val = lv;
      b1.en       = e;
      b1.up       = u;
      b1.load     = ld;
      b1.load_val = lv;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);

      // 1. reset overrides load and en
      tick();
      chk("rst_q0", 32'(b0.q), 32'd0);
      chk("rst_ovf0", 32'(b0.ovf), 32'd0);
      chk("rst_q1", 32'(b1.q), 32'd3);
      tick();
      chk("rst2_q0", 32'(b0.q), 32'd0);

      // 2. count up 0..9 then wrap
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      #1;
      chk("up_tc_at0", 32'(b0.tc), 32'd0);
      tick();
      chk("up_q1", 32'(b0.q), 32'd1);
      for (int i = 0; i < 8; i++) tick();
      chk("up_q9", 32'(b0.q), 32'd9);
      chk("up_tc9", 32'(b0.tc), 32'd1);
      chk("up_ovf_pre", 32'(b0.ovf), 32'd0);
      chk("up_q1_wrapped", 32'(b1.q), 32'd2);
      chk("up_ovf1", 32'(b1.ovf), 32'd1);
      tick();
`ifdef COUNTER_SATURATE_EN
      chk("up_sat_q", 32'(b0.q), 32'd9);
      chk("up_sat_tc", 32'(b0.tc), 32'd1);
`else
      chk("up_wrap_q", 32'(b0.q), 32'd0);
`endif
      chk("up_wrap_ovf", 32'(b0.ovf), 32'd1);

      // 3. count down from 0
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      #1;
      chk("dn_tc0", 32'(b0.tc), 32'd1);
      chk("dn_ovf_clr", 32'(b0.ovf), 32'd0);
      tick();
`ifdef COUNTER_SATURATE_EN
      chk("dn_sat_q", 32'(b0.q), 32'd0);
`else
      chk("dn_wrap_q", 32'(b0.q), 32'd9);
`endif
      chk("dn_wrap_ovf", 32'(b0.ovf), 32'd1);
      tick();
`ifdef COUNTER_SATURATE_EN
      chk("dn_sat_q2", 32'(b0.q), 32'd0);
`else
      chk("dn_q8", 32'(b0.q), 32'd8);
`endif

      // 4. load, clamp, hold
      drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
      #1;
      chk("ld_tc_masked", 32'(b0.tc), 32'd0);
      tick();
      chk("ld_q7", 32'(b0.q), 32'd7);
      chk("ld_ovf_clr", 32'(b0.ovf), 32'd0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd12);
      tick();
      chk("ld_clamp12", 32'(b0.q), 32'd9);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd10);
      tick();
      chk("ld_clamp10", 32'(b0.q), 32'd9);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd15);
      tick();
      chk("ld_clamp15", 32'(b0.q), 32'd9);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_q", 32'(b0.q), 32'd9);
      end
      chk("hold_tc", 32'(b0.tc), 32'd0);
      chk("hold_ovf", 32'(b0.ovf), 32'd0);

      // direction change on consecutive edges
      drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
      tick();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      tick();
      chk("dir_up_q4", 32'(b0.q), 32'd4);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      tick();
      chk("dir_dn_q3", 32'(b0.q), 32'd3);

      // 5. reset mid-count beats load
      drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
      tick();
      chk("mid_q0_5", 32'(b0.q), 32'd5);
      chk("mid_q1_5", 32'(b1.q), 32'd5);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
      tick();
      chk("mid_rst_q0", 32'(b0.q), 32'd0);
      chk("mid_rst_q1", 32'(b1.q), 32'd3);
      chk("mid_rst_ovf", 32'(b0.ovf), 32'd0);

      // tc is not gated by reset
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      #1;
      chk("rst_tc0", 32'(b0.tc), 32'd1);
      chk("rst_tc1", 32'(b1.tc), 32'd0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
